// File: rtl/led_status_capture.sv
// Front-panel LED status latch: synchronised, debounced push-button plus a WIDTH-bit
// LED bank driven in snapshot, live, sticky-OR or blinking-snapshot mode.
module led_status_capture #(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned BLINK_CYCLES    = 12500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] led,
    output logic             btn_level,
    output logic             press,
    output logic [7:0]       press_cnt
);

    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [DW-1:0] DebounceLast = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BlinkLast    = BW'(BLINK_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             lvl_d;
    logic [DW-1:0]    dcnt;
    logic [BW-1:0]    bcnt;
    logic             phase;
    logic [WIDTH-1:0] snap;

    // Two-flop synchroniser and debouncer; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            btn_level <= 1'b0;
            dcnt      <= '0;
            lvl_d     <= 1'b0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            lvl_d <= btn_level;
            if (s2 == btn_level) begin
                dcnt <= '0;
            end else if (dcnt == DebounceLast) begin
                btn_level <= s2;
                dcnt      <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

    assign press = btn_level & ~lvl_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_cnt <= 8'd0;
        end else if (press) begin
            press_cnt <= press_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap <= '0;
        end else begin
            unique case (mode)
                2'd0, 2'd3: if (press) snap <= din;
                2'd1:       snap <= din;
                2'd2:       snap <= press ? din : (snap | din);
                default:    snap <= snap;
            endcase
        end
    end

    // A press in blink mode restarts a full visible half-period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt  <= '0;
            phase <= 1'b1;
        end else if (mode == 2'd3) begin
            if (press) begin
                bcnt  <= '0;
                phase <= 1'b1;
            end else if (bcnt == BlinkLast) begin
                bcnt  <= '0;
                phase <= ~phase;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end else begin
            bcnt  <= '0;
            phase <= 1'b1;
        end
    end

    always_comb begin
        led = snap;
        if (mode == 2'd3 && !phase) begin
            led = '0;
        end
    end

endmodule

// File: tb/tb_led_status_capture.sv
// Scoreboard bench for led_status_capture with short debounce and blink periods.
module tb_led_status_capture;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEB   = 4;
    localparam int unsigned BLK   = 3;

    localparam int KLed = 0;
    localparam int KPress = 1;
    localparam int KLevel = 2;
    localparam int KCnt = 3;

    logic             clk;
    logic             rst_n;
    logic             btn;
    logic [1:0]       mode;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] led;
    logic             btn_level;
    logic             press;
    logic [7:0]       press_cnt;

    led_status_capture #(
        .WIDTH          (WIDTH),
        .DEBOUNCE_CYCLES(DEB),
        .BLINK_CYCLES   (BLK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn      (btn),
        .mode     (mode),
        .din      (din),
        .led      (led),
        .btn_level(btn_level),
        .press    (press),
        .press_cnt(press_cnt)
    );

    int unsigned edge_cnt = 0;
    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  exp_cnt  = 8'd0;
    logic [31:0] mon_got;

    int unsigned sb_at[$];
    int          sb_kind[$];
    logic [31:0] sb_val[$];
    string       sb_tag[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    task automatic push(input string tag, input int unsigned at, input int kind,
                        input logic [31:0] val);
        sb_at.push_back(at);
        sb_kind.push_back(kind);
        sb_val.push_back(val);
        sb_tag.push_back(tag);
    endtask

    // Compare every expectation due at this edge; anything overdue is a failure.
    always @(posedge clk) begin
        #1;
        for (int i = int'(sb_at.size()) - 1; i >= 0; i--) begin
            if (sb_at[i] <= edge_cnt) begin
                case (sb_kind[i])
                    KLed:    mon_got = 32'(led);
                    KPress:  mon_got = 32'(press);
                    KLevel:  mon_got = 32'(btn_level);
                    default: mon_got = 32'(press_cnt);
                endcase
                if (sb_at[i] == edge_cnt) check_eq(sb_tag[i], mon_got, sb_val[i]);
                else check_eq({"stale_", sb_tag[i]}, 32'(sb_at[i]), 32'(edge_cnt));
                sb_at.delete(i);
                sb_kind.delete(i);
                sb_val.delete(i);
                sb_tag.delete(i);
            end
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; btn is sampled at the next edge E, press is high after E+5.
    task automatic press_start(input string tag, input logic [15:0] d, output int unsigned pe);
        din     = d;
        btn     = 1'b1;
        pe      = edge_cnt + 1 + 1 + DEB;
        exp_cnt = exp_cnt + 8'd1;
        push({tag, "_press_pre"}, pe - 1, KPress, 32'd0);
        push({tag, "_press"}, pe, KPress, 32'd1);
        push({tag, "_press_post"}, pe + 1, KPress, 32'd0);
        push({tag, "_level_pre"}, pe - 1, KLevel, 32'd0);
        push({tag, "_level"}, pe, KLevel, 32'd1);
        push({tag, "_cnt"}, pe + 1, KCnt, 32'(exp_cnt));
    endtask

    task automatic press_finish(input int unsigned pe);
        while (edge_cnt < pe + 1) @(negedge clk);
        btn = 1'b0;
        wait_neg(6);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int unsigned pe;
        int unsigned k;
        logic [15:0] v;

        rst_n = 1'b1;
        btn   = 1'b0;
        mode  = 2'd0;
        din   = '0;
        #3 rst_n = 1'b0;
        wait_neg(3);
        check_eq("rst_led", 32'(led), 32'd0);
        check_eq("rst_press", 32'(press), 32'd0);
        check_eq("rst_level", 32'(btn_level), 32'd0);
        check_eq("rst_cnt", 32'(press_cnt), 32'd0);
        rst_n = 1'b1;
        wait_neg(2);

        // Snapshot press, then din changes must not reach the LEDs.
        press_start("snap", 16'hA5C3, pe);
        push("snap_led_pre", pe, KLed, 32'h0);
        push("snap_led", pe + 1, KLed, 32'hA5C3);
        press_finish(pe);
        din = 16'h0000;
        push("snap_hold", edge_cnt + 2, KLed, 32'hA5C3);
        push("release_level", edge_cnt + 1, KLevel, 32'd0);
        wait_neg(3);

        // Bounce shorter than the debounce window never changes the level.
        k = edge_cnt;
        for (int i = 1; i <= 12; i++) push("bounce_level", k + i, KLevel, 32'd0);
        push("bounce_press", k + 6, KPress, 32'd0);
        push("bounce_led", k + 12, KLed, 32'hA5C3);
        push("bounce_cnt", k + 12, KCnt, 32'd1);
        btn = 1'b1; wait_neg(3);
        btn = 1'b0; wait_neg(1);
        btn = 1'b1; wait_neg(3);
        btn = 1'b0; wait_neg(7);

        // Clear snap with a zero press, then accumulate in sticky-OR mode.
        press_start("zero", 16'h0000, pe);
        push("zero_led", pe + 1, KLed, 32'h0);
        press_finish(pe);
        k = edge_cnt;
        push("or_1", k + 1, KLed, 32'h0001);
        push("or_2", k + 2, KLed, 32'h0011);
        push("or_3", k + 3, KLed, 32'h0111);
        push("or_hold", k + 5, KLed, 32'h0111);
        mode = 2'd2; din = 16'h0001; wait_neg(1);
        din = 16'h0010; wait_neg(1);
        din = 16'h0100; wait_neg(1);
        din = 16'h0000; wait_neg(3);
        press_start("orpress", 16'h8000, pe);
        push("orpress_led_pre", pe, KLed, 32'h8111);
        push("orpress_led", pe + 1, KLed, 32'h8000);
        press_finish(pe);

        // Blink snapshot: 3 cycles on, 3 off; a press during off restarts on.
        mode = 2'd3;
        press_start("blink", 16'h00FF, pe);
        for (int i = 1; i <= 3; i++) push("blink_on1", pe + i, KLed, 32'h00FF);
        for (int i = 4; i <= 6; i++) push("blink_off", pe + i, KLed, 32'h0);
        for (int i = 7; i <= 9; i++) push("blink_on2", pe + i, KLed, 32'h00FF);
        push("blink_off2", pe + 10, KLed, 32'h0);
        press_finish(pe);
        k = pe;
        while (edge_cnt < k + 10) @(negedge clk);
        press_start("blinkp", 16'h0F0F, pe);
        push("blinkp_led_pre", pe, KLed, 32'h0);
        for (int i = 1; i <= 3; i++) push("blinkp_on", pe + i, KLed, 32'h0F0F);
        push("blinkp_off", pe + 4, KLed, 32'h0);
        press_finish(pe);

        // Press counter wraps modulo 256.
        mode = 2'd0;
        while (exp_cnt != 8'd254) begin
            press_start("cnt", 16'h1234, pe);
            press_finish(pe);
        end
        press_start("cnt_255", 16'h1234, pe);
        press_finish(pe);
        press_start("cnt_wrap0", 16'h4321, pe);
        push("cnt_wrap_led", pe + 1, KLed, 32'h4321);
        press_finish(pe);

        // Live mode follows din one cycle late; reset mid-debounce aborts everything.
        mode = 2'd1;
        for (int i = 0; i < 5; i++) begin
            v   = 16'($urandom);
            din = v;
            push("live", edge_cnt + 1, KLed, 32'(v));
            wait_neg(1);
        end
        btn = 1'b1;
        wait_neg(3);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_led", 32'(led), 32'd0);
        check_eq("arst_cnt", 32'(press_cnt), 32'd0);
        check_eq("arst_level", 32'(btn_level), 32'd0);
        exp_cnt = 8'd0;
        wait_neg(3);
        check_eq("arst_press", 32'(press), 32'd0);
        rst_n = 1'b1;
        press_start("rstpress", 16'hBEEF, pe);
        push("rstpress_led", pe + 1, KLed, 32'hBEEF);
        press_finish(pe);

        wait_neg(3);
        check_eq("sb_drain", 32'(sb_at.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
